// File: rtl/count_checker_pkg.sv
// Shared types and default sizes for the
// counter-stream checker.
package count_checker_pkg;

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCKING,
    LOCKED
  } chk_state_t;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_LOCK_LEN = 2;
  localparam int DEF_STAT_W   = 8;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones
// instead of rolling over.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;

endmodule

// File: rtl/count_stream_checker.sv
// Passive checker that locks onto an
// increment-by-one wrapping count stream.
module count_stream_checker
  import count_checker_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LOCK_LEN   = DEF_LOCK_LEN,
  parameter int ALLOW_HOLD = 0,
  parameter int STAT_W     = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  count,
  output logic              locked,
  output logic              err,
  output logic [WIDTH-1:0]  expected,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count
);

  chk_state_t       state_q;
  chk_state_t       state_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;
  logic [3:0]       run_q;
  logic [3:0]       run_d;
  logic             err_q;
  logic             err_d;
  logic             wrap_inc;
  logic [WIDTH-1:0] nxt;
  logic             is_inc;
  logic             is_hold;

  assign nxt     = prev_q + 1'b1;
  assign is_inc  = (count == nxt);
  assign is_hold = (ALLOW_HOLD != 0) && (count == prev_q);

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    run_d    = run_q;
    err_d    = 1'b0;
    wrap_inc = 1'b0;
    if (en) begin
      unique case (state_q)
        UNLOCKED: begin
          prev_d  = count;
          run_d   = '0;
          state_d = LOCKING;
        end
        LOCKING: begin
          if (!is_hold) begin
            prev_d = count;
            if (is_inc) begin
              run_d = run_q + 4'd1;
              if (run_d == 4'(LOCK_LEN)) begin
                state_d = LOCKED;
              end
            end else begin
              run_d = '0;
            end
          end
        end
        LOCKED: begin
          if (!is_hold) begin
            prev_d = count;
            if (is_inc) begin
              // wrap is the only correct step landing on zero
              wrap_inc = (count == '0);
            end else begin
              err_d   = 1'b1;
              run_d   = '0;
              state_d = LOCKING;
            end
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNLOCKED;
      prev_q  <= '0;
      run_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(
    .W(STAT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (err_d),
    .value(err_count)
  );

  sat_counter #(
    .W(STAT_W)
  ) u_wrap_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (wrap_inc),
    .value(wrap_count)
  );

  assign locked   = (state_q == LOCKED);
  assign err      = err_q;
  assign expected = nxt;

endmodule

// File: doc/count_stream_checker.md
# count_stream_checker

- Passive receiver-side checker for the free-running counter stream: samples a `count` bus, locks onto the increment-by-one, wrap-at-2^WIDTH sequence, and flags any deviation.
- Reports lock status, per-sample error pulses, and saturating error and wrap statistics.
- Sits beside the counter in simulation and FPGA builds as a self-check on the counter output.
- Has no influence on the counter itself.

## Interface
Parameters:
- `WIDTH`, 4, width of the observed count bus
- `LOCK_LEN`, 2, consecutive correct increments required to declare lock (1..15)
- `ALLOW_HOLD`, 0, when 1 a sample equal to the previous one is legal (stall); when 0 it is an error
- `STAT_W`, 8, width of the error and wrap statistic counters

Ports:
- `clk`  in  1  single clock; all sampling and state updates on its rising edge
- `rst`  in  1  reset, synchronous and active-high
- `en`  in  1  sample enable; when low the block holds all state
- `count`  in  WIDTH  observed counter value
- `locked`  out  1  high while in LOCKED state
- `err`  out  1  one-cycle pulse on a mismatch detected while locked
- `expected`  out  WIDTH  value predicted for the next sample (previous sample + 1, mod 2^WIDTH)
- `err_count`  out  STAT_W  saturating count of `err` pulses
- `wrap_count`  out  STAT_W  saturating count of observed max→0 transitions while locked

## Operation
- Registers:
  - `prev`: last accepted sample
  - `good_run`: 4-bit count of consecutive correct increments
  - state: UNLOCKED, LOCKING or LOCKED
- A sample is correct when `count == prev + 1`, truncated to WIDTH bits. The wrap from 2^WIDTH-1 to 0 is correct.
- Hold case: `count == prev` with ALLOW_HOLD=1 is neutral. No state or run change, no error, `prev` unchanged.
- UNLOCKED:
  - On `en`: `prev <= count`, `good_run <= 0`, go to LOCKING.
- LOCKING:
  - On `en` with a correct sample: `good_run++` and `prev <= count`.
  - When the incremented `good_run` equals LOCK_LEN, go to LOCKED.
  - On `en` with an incorrect sample: `good_run <= 0`, `prev <= count`. No `err` is raised.
- LOCKED:
  - On `en` with a correct sample: `prev <= count`. If it is a wrap (prev = all-ones, count = 0), `wrap_count` increments, saturating at 2^STAT_W-1.
  - On `en` with an incorrect sample: `err` pulses, `err_count` increments (saturating), `prev <= count`, `good_run <= 0`, go to LOCKING.
- When `en` is low, nothing changes and `err` is 0.
- Reset values, all applied on the next rising edge while `rst`=1:
  - state UNLOCKED
  - `locked`=0, `err`=0, `err_count`=0, `wrap_count`=0
  - `prev`=0, `expected`=1
- Reset mid-operation discards lock and statistics. Reset has priority over `en`.

## Timing
- All outputs are registered. There is no combinational path from `count` or `en` to any output.
- Error latency: `err` is high in the cycle after the edge that sampled the bad value, and lasts exactly one cycle.
- `err_count` updates on that same edge.
- Lock latency after reset release with a clean stream:
  - the first `en` sample enters LOCKING;
  - `locked` rises after LOCK_LEN more correct samples, i.e. LOCK_LEN+1 enabled edges.
- Back-to-back errors are impossible: after an error the block is in LOCKING and needs LOCK_LEN correct samples before `err` can fire again.
- `expected` is always `prev + 1` mod 2^WIDTH and updates on the same edge as `prev`.
- Saturation: at 2^STAT_W-1, further events leave the counter unchanged. No rollover.

## Structure
- Package `count_checker_pkg` holds:
  - state enum `chk_state_t` (UNLOCKED, LOCKING, LOCKED)
  - default constants for WIDTH, LOCK_LEN, STAT_W
- One natural sub-module, `sat_counter`:
  - parameterised width, synchronous `rst`, `inc` input, saturating output;
  - instantiated twice, for `err_count` and `wrap_count`.
- Top level holds the FSM, `prev`, `good_run` and the compare logic.

## Test plan
- Reset then clean stream, defaults, `en`=1, count 0,1,2,… → `locked`=1 on the 3rd enabled edge after reset release. `err` stays 0. `wrap_count`=1 after 15→0, `wrap_count`=3 after 50 cycles.
- Glitch: locked stream 5,6,7, then 9 → `err` pulses once the cycle after 9 is sampled, `err_count`=1, `locked`=0. Continuing 10,11 → relock, `err_count` still 1.
- Hold: count repeats 4,4 while locked:
  - ALLOW_HOLD=0 → `err`=1, `err_count`=1.
  - ALLOW_HOLD=1 → no error, `locked` stays 1, `expected`=5.
- Enable gating: `en`=0 for 10 cycles while count jumps randomly → no state change, `err`=0. Resume with `en`=1 at value `expected` → stays locked.
- Saturation: STAT_W=2, inject 5 errors (each followed by relock) → `err_count`=3 and it stays 3.
- Reset mid-operation: assert `rst` for 1 cycle while locked with `err_count`=2 → next edge `locked`=0, `err_count`=0, `wrap_count`=0, `expected`=1.
